// File: rtl/boot_sequencer.sv
// boot_sequencer: reset/fetch-enable sequencer with button debounce and run verdict capture
// Ports: clk_i/rst_i clock and sync active-high reset; btn_start_i/btn_reset_i raw buttons;
//        exit_valid_i/exit_zero_i subsystem exit status; core_rst_no/fetch_enable_o subsystem
//        control; running_o/done_o/pass_o/timeout_o/run_count_o run status.
// Optional: define BOOT_SEQ_WATCHDOG_EN to add a RUN watchdog limited by TIMEOUT_CYCLES.
module boot_sequencer #(
    parameter int          RST_HOLD_CYCLES    = 16,
    parameter int          FETCH_DELAY_CYCLES = 8,
    parameter int          DEBOUNCE_CYCLES    = 4,
    parameter bit          AUTO_START         = 1'b0,
    parameter logic [31:0] TIMEOUT_CYCLES     = 32'd1_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       btn_start_i,
    input  logic       btn_reset_i,
    input  logic       exit_valid_i,
    input  logic       exit_zero_i,
    output logic       core_rst_no,
    output logic       fetch_enable_o,
    output logic       running_o,
    output logic       done_o,
    output logic       pass_o,
    output logic       timeout_o,
    output logic [7:0] run_count_o
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    typedef enum logic [2:0] {S_HOLD, S_ARMED, S_WAIT, S_RUN, S_DONE} state_t;
    state_t        state;
    logic [31:0]   tmr;
    logic [1:0]    btn_s1, btn_s2, deb, press;
    logic [DW-1:0] dcnt [2];
    logic [2:0]    ev_s;
    logic [1:0]    ez_s;
    logic          exit_ev, wd_exp, start_press, rst_press;
    // index 0 = start, index 1 = reset
    assign start_press = press[0];
    assign rst_press   = press[1];
    assign exit_ev     = ev_s[1] & ~ev_s[2];
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            ev_s   <= '0;
            ez_s   <= '0;
            deb    <= '0;
            press  <= '0;
            for (int i = 0; i < 2; i++) dcnt[i] <= '0;
        end else begin
            btn_s1 <= {btn_reset_i, btn_start_i};
            btn_s2 <= btn_s1;
            ev_s   <= {ev_s[1:0], exit_valid_i};
            ez_s   <= {ez_s[0], exit_zero_i};
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (btn_s2[i] == deb[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    deb[i]   <= btn_s2[i];
                    dcnt[i]  <= '0;
                    // press pulse coincides with the cycle the level first reads 1
                    press[i] <= btn_s2[i];
                end else begin
                    dcnt[i] <= dcnt[i] + 1'b1;
                end
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= S_HOLD;
            tmr            <= '0;
            core_rst_no    <= 1'b0;
            fetch_enable_o <= 1'b0;
            running_o      <= 1'b0;
            done_o         <= 1'b0;
            pass_o         <= 1'b0;
            run_count_o    <= '0;
        end else if (rst_press) begin
            state          <= S_HOLD;
            tmr            <= '0;
            core_rst_no    <= 1'b0;
            fetch_enable_o <= 1'b0;
            running_o      <= 1'b0;
            done_o         <= 1'b0;
            pass_o         <= 1'b0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (tmr == 32'(RST_HOLD_CYCLES - 1)) begin
                        state       <= S_ARMED;
                        tmr         <= '0;
                        core_rst_no <= 1'b1;
                    end else begin
                        tmr <= tmr + 32'd1;
                    end
                end
                S_ARMED: begin
                    if (tmr == 32'(FETCH_DELAY_CYCLES - 1)) begin
                        state          <= AUTO_START ? S_RUN : S_WAIT;
                        tmr            <= '0;
                        fetch_enable_o <= AUTO_START;
                        running_o      <= AUTO_START;
                    end else begin
                        tmr <= tmr + 32'd1;
                    end
                end
                S_WAIT: begin
                    if (start_press) begin
                        state          <= S_RUN;
                        fetch_enable_o <= 1'b1;
                        running_o      <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (exit_ev || wd_exp) begin
                        state          <= S_DONE;
                        fetch_enable_o <= 1'b0;
                        running_o      <= 1'b0;
                        done_o         <= 1'b1;
                        // exit beats a simultaneous watchdog expiry
                        pass_o         <= exit_ev & ez_s[1];
                        run_count_o    <= run_count_o + {7'd0, run_count_o != 8'hFF};
                    end
                end
                S_DONE: begin
                    if (start_press) begin
                        state       <= S_HOLD;
                        tmr         <= '0;
                        core_rst_no <= 1'b0;
                        done_o      <= 1'b0;
                        pass_o      <= 1'b0;
                    end
                end
                default: state <= S_HOLD;
            endcase
        end
    end
`ifdef BOOT_SEQ_WATCHDOG_EN
    logic [31:0] wd;
    logic        timeout_q;
    assign wd_exp    = (TIMEOUT_CYCLES != 32'd0) && (wd == TIMEOUT_CYCLES - 32'd1);
    assign timeout_o = timeout_q;
    // wd sits at 0 outside RUN, so it starts from 0 on every RUN entry
    always_ff @(posedge clk_i) begin
        wd <= (rst_i || state != S_RUN) ? '0 : wd + 32'd1;
        if (rst_i || rst_press || (state == S_DONE && start_press)) timeout_q <= 1'b0;
        else if (state == S_RUN && !exit_ev && wd_exp) timeout_q <= 1'b1;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign wd_exp         = 1'b0;
    assign timeout_o      = 1'b0;
`endif
endmodule
